// File: rtl/decoupler_pkg.sv
// Shared constants, helpers and types for the decoupler FIFO.
// Imported by decoupler_fifo and decoupler_wrap_ptr.
package decoupler_pkg;

    localparam int LAT_REG    = 1;
    localparam int LAT_BYPASS = 0;

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    typedef struct packed {
        logic [31:0] hwm;
        logic [31:0] stall_cnt;
    } stats_t;

endpackage

// File: rtl/dti.sv
// Valid/ready/data stream interface used between gears.
// consumer receives a stream, producer emits one.
interface dti #(
    parameter int W = 16
) ();
    logic         valid;
    logic         ready;
    logic [W-1:0] data;

    modport consumer (input valid, input data, output ready);
    modport producer (output valid, output data, input ready);
endinterface

// File: rtl/decoupler_wrap_ptr.sv
// Modulo-DEPTH pointer: advances on inc, wraps DEPTH-1 -> 0.
// clr forces zero and wins over inc.
module decoupler_wrap_ptr
    import decoupler_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW   = ptr_w(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          inc,
    output logic [PW-1:0] ptr
);

    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= '0;
        end else if (clr) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= (ptr == LAST) ? '0 : ptr + PW'(1);
        end
    end

endmodule

// File: rtl/decoupler_fifo.sv
// Circular-buffer FIFO of any depth with optional fall-through bypass.
// Define DECOUPLER_FIFO_STATS_EN to add hwm and stall_cnt outputs.
module decoupler_fifo
    import decoupler_pkg::*;
#(
    parameter int DIN       = 16,
    parameter int DEPTH     = 4,
    parameter int LATENCY   = LAT_REG,
    parameter int AF_THRESH = DEPTH - 1,
    localparam int CW       = cnt_w(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    dti.consumer          din,
    dti.producer          dout,
    output logic [CW-1:0] level,
`ifdef DECOUPLER_FIFO_STATS_EN
    output logic [CW-1:0] hwm,
    output logic [31:0]   stall_cnt,
`endif
    output logic          almost_full
);

    localparam int PW = ptr_w(DEPTH);
    localparam logic BYP = (LATENCY == LAT_BYPASS);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [CW-1:0] AF = CW'(AF_THRESH);

    logic [DIN-1:0] mem [DEPTH];
    logic [PW-1:0]  w_ptr;
    logic [PW-1:0]  r_ptr;
    logic [CW-1:0]  count;
    logic [CW-1:0]  count_next;

    logic empty;
    logic byp_now;
    logic in_ready;
    logic out_valid;
    logic wr_hs;
    logic rd_hs;
    logic pass;
    logic do_wr;
    logic do_rd;

    assign empty   = (count == '0);
    assign byp_now = BYP & empty;

    assign in_ready  = (count < FULL) & ~flush;
    assign out_valid = ~flush & (~empty | (byp_now & din.valid));

    assign din.ready  = in_ready;
    assign dout.valid = out_valid;
    assign dout.data  = byp_now ? din.data : mem[r_ptr];

    assign wr_hs = din.valid & in_ready;
    assign rd_hs = out_valid & dout.ready;
    // A word handed straight through never touches storage
    assign pass  = byp_now & wr_hs & rd_hs;
    assign do_wr = wr_hs & ~pass;
    assign do_rd = rd_hs & ~pass;

    always_comb begin
        count_next = count;
        if (flush) begin
            count_next = '0;
        end else if (do_wr & ~do_rd) begin
            count_next = count + CW'(1);
        end else if (do_rd & ~do_wr) begin
            count_next = count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[w_ptr] <= din.data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count       <= '0;
            almost_full <= 1'b0;
        end else begin
            count       <= count_next;
            almost_full <= (count_next >= AF);
        end
    end

    assign level = count;

    decoupler_wrap_ptr #(.DEPTH(DEPTH)) u_wptr (
        .clk (clk),
        .rst (rst),
        .clr (flush),
        .inc (do_wr),
        .ptr (w_ptr)
    );

    decoupler_wrap_ptr #(.DEPTH(DEPTH)) u_rptr (
        .clk (clk),
        .rst (rst),
        .clr (flush),
        .inc (do_rd),
        .ptr (r_ptr)
    );

`ifdef DECOUPLER_FIFO_STATS_EN
    stats_t st;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st <= '0;
        end else if (flush) begin
            st <= '0;
        end else begin
            if (32'(count_next) > st.hwm) begin
                st.hwm <= 32'(count_next);
            end
            if (din.valid & ~in_ready & (st.stall_cnt != '1)) begin
                st.stall_cnt <= st.stall_cnt + 32'd1;
            end
        end
    end

    assign hwm       = st.hwm[CW-1:0];
    assign stall_cnt = st.stall_cnt;
`endif

endmodule

// File: doc/decoupler_fifo.md
Name: decoupler_fifo

Overview:
- Parametrised successor to the basic decoupler: a circular-buffer FIFO of arbitrary (non-power-of-two) depth between a dti consumer and a dti producer.
- Adds a selectable zero-latency bypass, a synchronous flush, and an occupancy level with an almost-full flag.
- Sits between gears that need rate decoupling plus backpressure visibility, e.g. ahead of bursty sinks or as a credit buffer.

Parameters:
- DIN, 16: payload width in bits; both interfaces carry data[DIN-1:0].
- DEPTH, 4: number of entries, ≥1, any integer (wrap handled explicitly, no power-of-two requirement).
- LATENCY, 1: 1 = registered output (write-to-read ≥1 cycle); 0 = fall-through bypass when empty.
- AF_THRESH, DEPTH-1: level at or above which almost_full is asserted, 1..DEPTH.
- Derived CW = $clog2(DEPTH+1): width of level.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous assert, active-low (rst=0 resets), synchronous deassert provided externally.
- flush  in  1  synchronous clear of all stored entries.
- din  dti.consumer  DIN  input stream (valid/ready/data).
- dout  dti.producer  DIN  output stream.
- level  out  CW  current stored-entry count.
- almost_full  out  1  level ≥ AF_THRESH.

Behaviour:
- State:
  - mem[0..DEPTH-1]
  - w_ptr, r_ptr in 0..DEPTH-1
  - count in 0..DEPTH
  - Pointers wrap DEPTH-1 → 0; neither is ever ≥ DEPTH.
- Reset (rst=0, async): count=0, w_ptr=r_ptr=0, dout.valid=0, level=0, almost_full=0, din.ready=1. mem is not reset. Reset mid-transfer discards all contents; no partial handshake survives.
- din.ready = (count < DEPTH) & ~flush. It never depends combinationally on dout.ready.
- Write: din.valid & din.ready → mem[w_ptr] <= din.data, w_ptr advances, except when bypassed (below).
- Read, LATENCY=1:
  - dout.valid = (count ≠ 0) & ~flush; dout.data = mem[r_ptr].
  - dout.valid & dout.ready → r_ptr advances.
- Read, LATENCY=0:
  - When count=0: dout.valid = din.valid & ~flush and dout.data = din.data (combinational).
  - If dout.ready in that cycle, the word passes through: no write, no pointer or count change.
  - When count≠0: behaves as LATENCY=1; incoming data is written and never bypassed, so order is preserved.
- count update:
  - +1 on write only; −1 on read only; unchanged on simultaneous write and read, or on bypass.
  - Full (count=DEPTH): write blocked even if a read occurs that cycle. Next cycle ready=1.
  - Empty (count=0, LATENCY=1): no read possible; a same-cycle write is visible on dout next cycle.
- flush=1:
  - din.ready=0 and dout.valid=0 in that cycle; no handshake occurs.
  - Next edge: count=0, r_ptr=w_ptr=0.
  - flush has priority over all other events.
- level = count (registered). almost_full = (count ≥ AF_THRESH), registered together with count.
- Data stability: dout.data holds while dout.valid & ~dout.ready (no rd advance). In LATENCY=0 bypass, stability relies on the upstream holding din.

Optional Feature:
- Macro DECOUPLER_FIFO_STATS_EN.
- Defined: adds two outputs.
  - hwm [CW]: high-water mark, max count since reset/flush; updated each cycle as max(hwm, count_next).
  - stall_cnt [31:0]: cycles with din.valid & ~din.ready, saturating at 32'hFFFF_FFFF.
  - Both reset to 0 on rst; both cleared by flush.
- Undefined: ports and logic absent; the rest of the behaviour is identical.

Decomposition:
- Package decoupler_pkg:
  - LAT_REG=1 and LAT_BYPASS=0 constants.
  - function cnt_w(depth) returning $clog2(depth+1).
  - typedef stats_t {hwm, stall_cnt} used under the macro.
- Sub-module decoupler_wrap_ptr (params DEPTH; ports clk, rst, clr, inc, ptr): modulo-DEPTH counter, instantiated for w_ptr and r_ptr.

Test Plan:
- DEPTH=3, LATENCY=1, dout.ready=0, push 0xA1,0xA2,0xA3,0xA4 → first three accepted, din.ready=0 on 4th, level=3, almost_full=1 (AF_THRESH=2); then ready=1 → dout 0xA1,0xA2,0xA3 in order, 0xA4 accepted the cycle after the first pop.
- DEPTH=5 wrap: 12 push/pop pairs with random ready → output equals input sequence; pointers wrap 4→0; level never exceeds 5.
- LATENCY=0, empty, din.valid=1 data 0x55, dout.ready=1 → dout.valid=1, data=0x55 same cycle, level stays 0; with dout.ready=0 → level=1 next cycle and 0x55 is presented until taken.
- Full with simultaneous pop (count=DEPTH, dout.ready=1, din.valid=1) → pop only, level=DEPTH−1, din.ready=1 next cycle.
- flush at level=2 with din.valid=1 → no handshake that cycle; next cycle level=0, dout.valid=0; rst=0 asserted mid-burst → outputs reach reset values without a clock edge.
- With DECOUPLER_FIFO_STATS_EN: fill to 3 of 4, drain, hold din.valid 5 cycles while full → hwm=4, stall_cnt=5; flush → both 0.
